modulo_controlador_varredura_display: RTL

Time-multiplexed scan controller that shares one BCD/extended-code to 7-segment decoder among four digits of a common-anode display. It holds a 4-digit, 4-bit-per-digit display image plus per-digit decimal points. It drives the decoder's 4-bit code input and the active-low digit enables, inserting a blanking interval before each digit to prevent ghosting. New images are accepted through a ready/load handshake and committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/modulo_controlador_varredura_display_if.sv | 23 ++
 rtl/modulo_controlador_varredura_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/modulo_controlador_varredura_display_if.sv
// Handshake and display bus of the 4-digit scan controller.
// The master drives the image and control; the slave (controller) drives the display.
interface modulo_controlador_varredura_display_if;
  logic        ENABLE;
  logic        LOAD;
  logic [15:0] DATA;
  logic [3:0]  DP_IN;
  logic [3:0]  D7SEG;
  logic [3:0]  DIG_N;
  logic        DP_N;
  logic        READY;
  logic        FRAME;

  modport master (
    output ENABLE, LOAD, DATA, DP_IN,
    input  D7SEG, DIG_N, DP_N, READY, FRAME
  );

  modport slave (
    input  ENABLE, LOAD, DATA, DP_IN,
    output D7SEG, DIG_N, DP_N, READY, FRAME
  );
endinterface

// File: rtl/modulo_controlador_varredura_display.sv
// Time-multiplexed scan controller for a 4-digit common-anode display with
// per-slot blanking and frame-synchronous commit of new images.
module modulo_controlador_varredura_display #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 500
) (
  input logic                                 CLK,
  input logic                                 RST,
  modulo_controlador_varredura_display_if.slave bus
);

  localparam int unsigned   CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  dp_q, dp_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        pending_q, pending_d;

  logic [3:0]  dig_n_q, dig_n_d;
  logic [3:0]  seg_q, seg_d;
  logic        dp_n_q, dp_n_d;
  logic        ready_q, ready_d;
  logic        frame_q, frame_d;

  logic        commit;
  logic        accept;
  logic [3:0]  cur_digit;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    disp_d      = disp_q;
    dp_d        = dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    frame_d     = 1'b0;
    commit      = 1'b0;
    accept      = bus.LOAD & ~pending_q;

    unique case (state_q)
      ST_IDLE: begin
        commit = pending_q;
        if (bus.ENABLE) begin
          state_d = ST_BLANK;
          slot_d  = 2'd0;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (!bus.ENABLE) begin
          state_d = ST_IDLE;
          slot_d  = 2'd0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!bus.ENABLE) begin
          state_d = ST_IDLE;
          slot_d  = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          slot_d  = slot_q + 2'd1;
          if (slot_q == 2'd3) begin
            frame_d = 1'b1;
            commit  = pending_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = 2'd0;
        cnt_d   = '0;
      end
    endcase

    // Commit sees the old pending flag, so a load on a boundary waits one more frame.
    if (commit) begin
      disp_d    = shadow_q;
      dp_d      = shadow_dp_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d    = bus.DATA;
      shadow_dp_d = bus.DP_IN;
      pending_d   = 1'b1;
    end

    // Outputs are derived from next-state values so the registers line up with the state.
    cur_digit = disp_d[{slot_d, 2'b00} +: 4];
    dig_n_d   = 4'b1111;
    seg_d     = 4'h0;
    dp_n_d    = 1'b1;
    unique case (state_d)
      ST_BLANK: seg_d = cur_digit;
      ST_SHOW: begin
        seg_d   = cur_digit;
        dig_n_d = ~(4'b0001 << slot_d);
        dp_n_d  = ~dp_d[slot_d];
      end
      default: ;
    endcase
    ready_d = ~pending_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      slot_q      <= 2'd0;
      cnt_q       <= '0;
      disp_q      <= '0;
      dp_q        <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pending_q   <= 1'b0;
      dig_n_q     <= 4'b1111;
      seg_q       <= 4'h0;
      dp_n_q      <= 1'b1;
      ready_q     <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
      dp_q        <= dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      dig_n_q     <= dig_n_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      ready_q     <= ready_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.DIG_N = dig_n_q;
  assign bus.D7SEG = seg_q;
  assign bus.DP_N  = dp_n_q;
  assign bus.READY = ready_q;
  assign bus.FRAME = frame_q;

endmodule
